// File: rtl/sd_cmd_arb.sv
// Round-robin arbiter sequencing two requesters onto one shared SD SPI command engine.
// Grant 1 cycle after req, start 1 cycle later unless eng_busy stalls it; handles R1 timeout, CS gaps, lock chains.
module sd_cmd_arb #(
  parameter int GAP_CLKS = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic        sd_ck,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  lock,
  input  logic [47:0] cmd0,
  input  logic [47:0] cmd1,
  output logic [1:0]  gnt,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        eng_start,
  output logic [47:0] eng_cmd,
  input  logic        eng_busy,
  input  logic        eng_resp_valid,
  input  logic [7:0]  eng_resp,
  output logic        sd_csn
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [9:0] TMO_LD = 10'(TIMEOUT);
  // The entry cycle counts as the first gap cycle, so load one less.
  localparam logic [7:0] GAP_LD = 8'(GAP_CLKS - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic        start_q, start_d;
  logic [47:0] cmd_q, cmd_d;
  logic        csn_q, csn_d;
  logic [9:0]  tcnt_q, tcnt_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic        win;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;
    cmd_d     = cmd_q;
    csn_d     = csn_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    win       = 1'b0;
    case (state_q)
      S_IDLE: begin
        csn_d = 1'b1;
        gnt_d = 2'b00;
        if (req != 2'b00) begin
          win     = (req == 2'b11) ? ~last_q : req[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          cmd_d   = win ? cmd1 : cmd0;
          last_d  = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!eng_busy) begin
          start_d = 1'b1;
          csn_d   = 1'b0;
          tcnt_d  = TMO_LD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        csn_d = 1'b0;
        // A response arriving on the expiry cycle still counts as a response.
        if (eng_resp_valid || tcnt_q == '0) begin
          done_d    = 1'b1;
          resp_d    = eng_resp_valid ? eng_resp : 8'hFF;
          timeout_d = ~eng_resp_valid;
          csn_d     = ~lock[last_q];
          gcnt_d    = GAP_LD;
          state_d   = S_GAP;
        end else begin
          tcnt_d = tcnt_q - 10'd1;
        end
      end
      default: begin
        csn_d = ~lock[last_q];
        if (gcnt_q == '0) begin
          if (lock[last_q] && req[last_q]) begin
            cmd_d   = last_q ? cmd1 : cmd0;
            state_d = S_ISSUE;
          end else begin
            gnt_d   = 2'b00;
            csn_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge sd_ck or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      last_q    <= 1'b1;
      done_q    <= 1'b0;
      resp_q    <= 8'hFF;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      cmd_q     <= {48{1'b1}};
      csn_q     <= 1'b1;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      cmd_q     <= cmd_d;
      csn_q     <= csn_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign resp      = resp_q;
  assign timeout   = timeout_q;
  assign eng_start = start_q;
  assign eng_cmd   = cmd_q;
  assign sd_csn    = csn_q;

endmodule

// File: tb/tb_sd_cmd_arb.sv
// Randomized bench for sd_cmd_arb: transaction-level timing/grant model checked against logged DUT events.
`timescale 1ns/1ps
module tb_sd_cmd_arb;
  localparam int G = 8;
  localparam int T = 16;

  logic        sd_ck = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  lock = 2'b00;
  logic [47:0] cmd0 = '0;
  logic [47:0] cmd1 = '0;
  logic        eng_busy = 1'b0;
  logic        eng_resp_valid = 1'b0;
  logic [7:0]  eng_resp = 8'h00;
  logic [1:0]  gnt;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;
  logic        eng_start;
  logic [47:0] eng_cmd;
  logic        sd_csn;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_last = 1;
  int eng_delay = 5;
  logic [7:0] eng_byte = 8'h00;
  bit eng_silent = 1'b0;

  int          st_cyc[$];
  logic [47:0] st_cmd[$];
  logic [1:0]  st_gnt[$];
  int          dn_cyc[$];
  logic [7:0]  dn_resp[$];
  logic        dn_to[$];
  logic [1:0]  gnt_log [0:8191];
  logic        csn_log [0:8191];

  sd_cmd_arb #(.GAP_CLKS(G), .TIMEOUT(T)) dut (
    .sd_ck(sd_ck), .rst(rst), .req(req), .lock(lock), .cmd0(cmd0), .cmd1(cmd1),
    .gnt(gnt), .done(done), .resp(resp), .timeout(timeout), .eng_start(eng_start),
    .eng_cmd(eng_cmd), .eng_busy(eng_busy), .eng_resp_valid(eng_resp_valid),
    .eng_resp(eng_resp), .sd_csn(sd_csn)
  );

  always #5 sd_ck = ~sd_ck;
  always @(posedge sd_ck) cyc <= cyc + 1;

  always @(negedge sd_ck) begin
    if (cyc < 8192) begin
      gnt_log[cyc] = gnt;
      csn_log[cyc] = sd_csn;
    end
    if (eng_start) begin
      st_cyc.push_back(cyc);
      st_cmd.push_back(eng_cmd);
      st_gnt.push_back(gnt);
    end
    if (done) begin
      dn_cyc.push_back(cyc);
      dn_resp.push_back(resp);
      dn_to.push_back(timeout);
    end
  end

  // Engine stand-in: answers eng_delay cycles after each start unless silent.
  initial begin
    forever begin
      @(negedge sd_ck);
      if (eng_start && !eng_silent) begin
        repeat (eng_delay) @(negedge sd_ck);
        eng_resp = eng_byte;
        eng_resp_valid = 1'b1;
        @(negedge sd_ck);
        eng_resp_valid = 1'b0;
        eng_resp = 8'($urandom);
      end
    end
  end

  function automatic logic [1:0] onehot(int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  // Done lands one cycle after the edge that sees the response, or TIMEOUT+1 after start.
  function automatic int exp_done(int s, int d, bit silent);
    if (silent || d > T) return s + T + 1;
    return s + d + 1;
  endfunction

  function automatic int count_csn(int a, int b, logic v);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < 8192 && csn_log[i] === v) n++;
    return n;
  endfunction

  function automatic int count_gnt_ne(int a, int b, logic [1:0] v);
    int n = 0;
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < 8192 && gnt_log[i] !== v) n++;
    return n;
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_cmd.delete(); st_gnt.delete();
    dn_cyc.delete(); dn_resp.delete(); dn_to.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge sd_ck);
  endtask

  task automatic wait_dn(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sd_ck);
      #1;
      if (dn_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge sd_ck);
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_chk++; if (resp !== 8'hFF) begin n_fail++; $display("FAIL reset_resp: got %h exp ff", resp); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    n_chk++; if (eng_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b exp 0", eng_start); end
    n_chk++; if (eng_cmd !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_cmd: got %h exp ffffffffffff", eng_cmd); end
    n_chk++; if (sd_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b exp 1", sd_csn); end
    rst = 1'b0;
    model_last = 1;
    settle(2);
  endtask

  task automatic test_single();
    int r, d, c, s, e;
    logic [47:0] fr;
    logic [7:0] by;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      r  = (it == 0) ? 0 : int'($urandom_range(0, 1));
      fr = (it == 0) ? 48'h40_0000_0000_95 : {16'($urandom), 32'($urandom)};
      by = (it == 0) ? 8'h01 : 8'($urandom_range(0, 127));
      d  = (it == 0) ? 5 : int'($urandom_range(1, T - 1));
      clear_logs();
      eng_delay = d; eng_byte = by; eng_silent = 1'b0;
      @(negedge sd_ck);
      c = cyc;
      if (r == 0) cmd0 = fr; else cmd1 = fr;
      req = onehot(r);
      wait_dn(1, 60, ok);
      req = 2'b00;
      settle(G + 4);
      n_chk++;
      if (!ok || st_cyc.size() != 1) begin
        n_fail++; $display("FAIL single_count: starts %0d dones %0d exp 1 and 1", st_cyc.size(), dn_cyc.size());
      end else begin
        s = c + 2;
        e = exp_done(s, d, 1'b0);
        n_chk++; if (gnt_log[c + 1] !== onehot(r)) begin n_fail++; $display("FAIL single_gnt: got %b exp %b", gnt_log[c + 1], onehot(r)); end
        n_chk++; if (st_cyc[0] != s) begin n_fail++; $display("FAIL single_start: cycle %0d exp %0d", st_cyc[0], s); end
        n_chk++; if (st_cmd[0] !== fr) begin n_fail++; $display("FAIL single_cmd: got %h exp %h", st_cmd[0], fr); end
        n_chk++; if (dn_cyc[0] != e) begin n_fail++; $display("FAIL single_done: cycle %0d exp %0d", dn_cyc[0], e); end
        n_chk++; if (dn_resp[0] !== by || dn_to[0] !== 1'b0) begin n_fail++; $display("FAIL single_resp: got %h/%b exp %h/0", dn_resp[0], dn_to[0], by); end
        n_chk++; if (count_csn(s, e - 1, 1'b0) != e - s) begin n_fail++; $display("FAIL single_csn_low: low %0d exp %0d", count_csn(s, e - 1, 1'b0), e - s); end
        n_chk++; if (count_csn(e, e + G - 1, 1'b1) != G) begin n_fail++; $display("FAIL single_gap: high %0d exp %0d", count_csn(e, e + G - 1, 1'b1), G); end
        n_chk++; if (gnt_log[e + G - 1] !== onehot(r) || gnt_log[e + G] !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b,%b exp %b,00", gnt_log[e + G - 1], gnt_log[e + G], onehot(r)); end
      end
      model_last = r;
    end
  endtask

  task automatic test_tie();
    int c, d, w1, w2;
    logic [47:0] f0, f1;
    logic [7:0] by;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      w1 = 1 - model_last; w2 = model_last;
      f0 = {16'($urandom), 32'($urandom)};
      f1 = {16'($urandom), 32'($urandom)};
      d  = $urandom_range(1, T);
      by = 8'($urandom_range(0, 127));
      clear_logs();
      eng_delay = d; eng_byte = by;
      @(negedge sd_ck);
      c = cyc; cmd0 = f0; cmd1 = f1; req = 2'b11;
      wait_dn(2, 150, ok);
      req = 2'b00;
      settle(G + 4);
      n_chk++;
      if (!ok || st_cyc.size() != 2) begin
        n_fail++; $display("FAIL tie_count: starts %0d dones %0d exp 2 and 2", st_cyc.size(), dn_cyc.size());
      end else begin
        n_chk++; if (st_cyc[0] != c + 2) begin n_fail++; $display("FAIL tie_start0: cycle %0d exp %0d", st_cyc[0], c + 2); end
        n_chk++; if (st_gnt[0] !== onehot(w1) || st_cmd[0] !== (w1 == 1 ? f1 : f0)) begin n_fail++; $display("FAIL tie_first: gnt %b cmd %h exp %b", st_gnt[0], st_cmd[0], onehot(w1)); end
        n_chk++; if (st_gnt[1] !== onehot(w2) || st_cmd[1] !== (w2 == 1 ? f1 : f0)) begin n_fail++; $display("FAIL tie_second: gnt %b cmd %h exp %b", st_gnt[1], st_cmd[1], onehot(w2)); end
        n_chk++; if (st_cyc[1] - dn_cyc[0] != G + 2) begin n_fail++; $display("FAIL tie_spacing: %0d exp %0d", st_cyc[1] - dn_cyc[0], G + 2); end
        n_chk++; if (count_csn(dn_cyc[0], st_cyc[1] - 1, 1'b0) != 0 || count_csn(dn_cyc[0], st_cyc[1] - 1, 1'b1) < G) begin n_fail++; $display("FAIL tie_gap: high %0d need >= %0d all high", count_csn(dn_cyc[0], st_cyc[1] - 1, 1'b1), G); end
        n_chk++; if (dn_resp[1] !== by || dn_to[1] !== 1'b0) begin n_fail++; $display("FAIL tie_resp: got %h/%b exp %h/0", dn_resp[1], dn_to[1], by); end
      end
      model_last = w2;
    end
  endtask

  task automatic test_timeout();
    int r;
    bit ok;
    r = $urandom_range(0, 1);
    clear_logs();
    eng_silent = 1'b1;
    @(negedge sd_ck);
    req = onehot(r);
    wait_dn(1, T + 20, ok);
    req = 2'b00;
    settle(G + 4);
    eng_silent = 1'b0;
    n_chk++;
    if (!ok || st_cyc.size() != 1 || dn_cyc.size() != 1) begin
      n_fail++; $display("FAIL timeout_count: starts %0d dones %0d exp 1 and 1", st_cyc.size(), dn_cyc.size());
    end else begin
      n_chk++; if (dn_cyc[0] != exp_done(st_cyc[0], 0, 1'b1)) begin n_fail++; $display("FAIL timeout_latency: %0d exp %0d", dn_cyc[0] - st_cyc[0], T + 1); end
      n_chk++; if (dn_resp[0] !== 8'hFF || dn_to[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_flags: got %h/%b exp ff/1", dn_resp[0], dn_to[0]); end
      n_chk++; if (st_gnt[0] !== onehot(r)) begin n_fail++; $display("FAIL timeout_gnt: got %b exp %b", st_gnt[0], onehot(r)); end
    end
    model_last = r;
  endtask

  task automatic test_lock();
    int c, d;
    logic [47:0] f55, f41, f0;
    logic [7:0] by;
    bit ok1, ok2, ok3;
    f55 = 48'h77_0000_0000_65;
    f41 = 48'h69_4000_0000_77;
    f0  = {16'($urandom), 32'($urandom)};
    d   = $urandom_range(1, T - 1);
    by  = 8'($urandom_range(0, 127));
    clear_logs();
    eng_delay = d; eng_byte = by;
    @(negedge sd_ck);
    c = cyc; cmd0 = f0; cmd1 = f55; lock = 2'b10; req = 2'b10;
    settle(2);
    req[0] = 1'b1;
    wait_dn(1, 60, ok1);
    cmd1 = f41;
    wait_dn(2, 60, ok2);
    lock = 2'b00; req[1] = 1'b0;
    wait_dn(3, 60, ok3);
    req = 2'b00;
    settle(G + 4);
    n_chk++;
    if (!(ok1 && ok2 && ok3) || st_cyc.size() != 3) begin
      n_fail++; $display("FAIL lock_count: starts %0d dones %0d exp 3 and 3", st_cyc.size(), dn_cyc.size());
    end else begin
      n_chk++; if (st_cyc[0] != c + 2) begin n_fail++; $display("FAIL lock_start0: cycle %0d exp %0d", st_cyc[0], c + 2); end
      n_chk++; if (st_gnt[0] !== 2'b10 || st_cmd[0] !== f55) begin n_fail++; $display("FAIL lock_cmd55: gnt %b cmd %h exp 10 %h", st_gnt[0], st_cmd[0], f55); end
      n_chk++; if (st_gnt[1] !== 2'b10 || st_cmd[1] !== f41) begin n_fail++; $display("FAIL lock_acmd41: gnt %b cmd %h exp 10 %h", st_gnt[1], st_cmd[1], f41); end
      n_chk++; if (st_cyc[1] - dn_cyc[0] != G + 1) begin n_fail++; $display("FAIL lock_relock_time: %0d exp %0d", st_cyc[1] - dn_cyc[0], G + 1); end
      n_chk++; if (count_csn(st_cyc[0], dn_cyc[1], 1'b1) != 0) begin n_fail++; $display("FAIL lock_csn: high cycles %0d exp 0", count_csn(st_cyc[0], dn_cyc[1], 1'b1)); end
      n_chk++; if (count_gnt_ne(st_cyc[0], dn_cyc[1], 2'b10) != 0) begin n_fail++; $display("FAIL lock_gnt_held: off cycles %0d exp 0", count_gnt_ne(st_cyc[0], dn_cyc[1], 2'b10)); end
      n_chk++; if (st_gnt[2] !== 2'b01 || st_cmd[2] !== f0 || st_cyc[2] - dn_cyc[1] != G + 2) begin n_fail++; $display("FAIL lock_after: gnt %b cmd %h gap %0d exp 01 %h %0d", st_gnt[2], st_cmd[2], st_cyc[2] - dn_cyc[1], f0, G + 2); end
      n_chk++; if (dn_resp[1] !== by || dn_to[1] !== 1'b0) begin n_fail++; $display("FAIL lock_resp: got %h/%b exp %h/0", dn_resp[1], dn_to[1], by); end
    end
    model_last = 0;
  endtask

  task automatic test_coincide();
    int r;
    logic [7:0] by;
    bit ok;
    r  = $urandom_range(0, 1);
    by = 8'($urandom_range(0, 127));
    clear_logs();
    eng_delay = T; eng_byte = by;
    @(negedge sd_ck);
    req = onehot(r);
    wait_dn(1, T + 20, ok);
    req = 2'b00;
    settle(G + 4);
    n_chk++;
    if (!ok || st_cyc.size() != 1) begin
      n_fail++; $display("FAIL coincide_count: starts %0d dones %0d exp 1 and 1", st_cyc.size(), dn_cyc.size());
    end else begin
      n_chk++; if (dn_cyc[0] != exp_done(st_cyc[0], T, 1'b0)) begin n_fail++; $display("FAIL coincide_latency: %0d exp %0d", dn_cyc[0] - st_cyc[0], T + 1); end
      n_chk++; if (dn_resp[0] !== by || dn_to[0] !== 1'b0) begin n_fail++; $display("FAIL coincide_resp: got %h/%b exp %h/0", dn_resp[0], dn_to[0], by); end
    end
    model_last = r;
  endtask

  task automatic test_busy();
    int r, c, b, d;
    logic [7:0] by;
    bit ok;
    r  = $urandom_range(0, 1);
    d  = $urandom_range(1, T - 1);
    by = 8'($urandom_range(0, 127));
    clear_logs();
    eng_delay = d; eng_byte = by;
    @(negedge sd_ck);
    c = cyc; eng_busy = 1'b1; req = onehot(r);
    repeat (11) @(negedge sd_ck);
    b = cyc; eng_busy = 1'b0;
    wait_dn(1, 60, ok);
    req = 2'b00;
    settle(G + 4);
    n_chk++;
    if (!ok || st_cyc.size() != 1) begin
      n_fail++; $display("FAIL busy_count: starts %0d dones %0d exp 1 and 1", st_cyc.size(), dn_cyc.size());
    end else begin
      n_chk++; if (gnt_log[c + 1] !== onehot(r)) begin n_fail++; $display("FAIL busy_gnt: got %b exp %b", gnt_log[c + 1], onehot(r)); end
      n_chk++; if (st_cyc[0] != b + 1) begin n_fail++; $display("FAIL busy_start: cycle %0d exp %0d", st_cyc[0], b + 1); end
      n_chk++; if (dn_cyc[0] != exp_done(st_cyc[0], d, 1'b0) || dn_resp[0] !== by) begin n_fail++; $display("FAIL busy_done: cycle %0d resp %h exp %0d %h", dn_cyc[0], dn_resp[0], exp_done(st_cyc[0], d, 1'b0), by); end
    end
    model_last = r;
  endtask

  task automatic test_reset_wait();
    int r, c, d;
    logic [47:0] fr;
    logic [7:0] by;
    bit ok;
    r = $urandom_range(0, 1);
    clear_logs();
    eng_silent = 1'b1;
    @(negedge sd_ck);
    req = onehot(r);
    for (int i = 0; i < 10 && st_cyc.size() == 0; i++) @(negedge sd_ck);
    settle(3);
    rst = 1'b1; req = 2'b00;
    #1;
    n_chk++; if (sd_csn !== 1'b1) begin n_fail++; $display("FAIL rstwait_csn: got %b exp 1", sd_csn); end
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rstwait_gnt: got %b exp 00", gnt); end
    n_chk++; if (done !== 1'b0 || eng_start !== 1'b0) begin n_fail++; $display("FAIL rstwait_pulses: done %b start %b exp 0 0", done, eng_start); end
    n_chk++; if (resp !== 8'hFF) begin n_fail++; $display("FAIL rstwait_resp: got %h exp ff", resp); end
    @(negedge sd_ck);
    rst = 1'b0;
    model_last = 1;
    eng_silent = 1'b0;
    settle(2);
    fr = {16'($urandom), 32'($urandom)};
    by = 8'($urandom_range(0, 127));
    d  = $urandom_range(1, T - 1);
    clear_logs();
    eng_delay = d; eng_byte = by;
    @(negedge sd_ck);
    c = cyc; cmd1 = fr; req = 2'b10;
    wait_dn(1, 60, ok);
    req = 2'b00;
    settle(G + 4);
    n_chk++;
    if (!ok || st_cyc.size() != 1) begin
      n_fail++; $display("FAIL rstwait_count: starts %0d dones %0d exp 1 and 1", st_cyc.size(), dn_cyc.size());
    end else begin
      n_chk++; if (gnt_log[c + 1] !== 2'b10 || st_cyc[0] != c + 2) begin n_fail++; $display("FAIL rstwait_grant: gnt %b start %0d exp 10 %0d", gnt_log[c + 1], st_cyc[0], c + 2); end
      n_chk++; if (st_cmd[0] !== fr) begin n_fail++; $display("FAIL rstwait_cmd: got %h exp %h", st_cmd[0], fr); end
      n_chk++; if (dn_resp[0] !== by || dn_cyc[0] != exp_done(st_cyc[0], d, 1'b0)) begin n_fail++; $display("FAIL rstwait_done: resp %h cycle %0d exp %h %0d", dn_resp[0], dn_cyc[0], by, exp_done(st_cyc[0], d, 1'b0)); end
    end
    model_last = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_lock();
    test_coincide();
    test_busy();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sd_cmd_arb.md
# sd_cmd_arb

Command-slot arbiter and sequencer for the shared SD-card SPI command engine. Two requesters share one 48-bit command shifter and one chip-select: requester 0 is the card-initialisation sequencer and requester 1 is the block read/write sequencer. The block grants the engine round-robin and issues each command. It bounds the response wait with a timeout, returns the R1 byte, and enforces inter-command CS-high gaps. A lock input lets a requester chain commands atomically, for example CMD55 followed by ACMD41.

## Interface
Parameters:
- GAP_CLKS, 8: clock cycles `sd_csn` is held high between commands when not locked (1..255).
- TIMEOUT, 255: cycles to wait for `eng_resp_valid` after `eng_start` (1..1023).

Ports:
- sd_ck  in  1  Clock. All state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- req  in  2  Per-requester request. Held high until `done` is seen for that requester.
- lock  in  2  Per-requester lock. Sampled at end of GAP to keep the grant.
- cmd0  in  48  Requester 0 command frame (cmd, arg, crc, stop).
- cmd1  in  48  Requester 1 command frame.
- gnt  out  2  One-hot grant. Reset 2'b00.
- done  out  1  One-cycle pulse: command finished for the granted requester. Reset 0.
- resp  out  8  R1 byte for the finished command. Valid with `done`, held until next `done`. Reset 8'hFF.
- timeout  out  1  Set with `done` when no response arrived, held until next `done`. Reset 0.
- eng_start  out  1  One-cycle pulse starting the engine. Reset 0.
- eng_cmd  out  48  Frame latched at grant or relock. Reset 48'hFFFF_FFFF_FFFF.
- eng_busy  in  1  Engine still shifting.
- eng_resp_valid  in  1  One-cycle pulse: `eng_resp` holds the R1 byte.
- eng_resp  in  8  Engine response byte.
- sd_csn  out  1  SPI chip select, active low. Reset 1.

## Operation
- States: IDLE, ISSUE, WAIT, GAP. Reset state is IDLE. All outputs are registered.
- **IDLE**
  - `sd_csn`=1, `gnt`=0.
  - If any `req` is set, choose a winner:
    - Single request: that requester.
    - Both requesting: the requester not granted last. `last_gnt` resets to 1, so requester 0 wins the first tie.
  - On the winner: set `gnt`, latch its frame into `eng_cmd`, update `last_gnt`, go to ISSUE.
- **ISSUE**
  - While `eng_busy`=1: stay in ISSUE with no start.
  - Otherwise: pulse `eng_start`, drive `sd_csn`=0, load the timeout counter with TIMEOUT, go to WAIT.
- **WAIT**
  - `sd_csn`=0. The counter decrements by 1 per cycle and saturates at 0.
  - If `eng_resp_valid`=1: latch `resp`=`eng_resp`, set `timeout`=0, pulse `done`, go to GAP.
  - Else if counter==0: set `resp`=8'hFF, `timeout`=1, pulse `done`, go to GAP.
  - If `eng_resp_valid` and counter==0 occur in the same cycle, the response wins and `timeout`=0.
- **GAP**
  - Load the gap counter with GAP_CLKS on entry and count down to 0.
  - `sd_csn`=1 unless `lock`[owner]=1, in which case `sd_csn` stays 0.
  - At count 0:
    - If `lock`[owner]=1 and `req`[owner]=1: latch the owner's frame again and go to ISSUE. No re-arbitration; `gnt` is unchanged.
    - Otherwise: clear `gnt` and go to IDLE.
- Dropping `req` before `done` does not abort the command. The command completes and `done` still pulses.
- Asserting `rst` in any state forces the reset values immediately: `sd_csn`=1, `gnt`=0, `eng_start`=0. The next command starts from IDLE.
- A requester whose `req` is low is never granted.

## Timing
- From `req` sampled high in IDLE at edge k:
  - `gnt` and `eng_cmd` are valid after edge k.
  - `eng_start` is high for the cycle after edge k+1, provided `eng_busy`=0.
- `done` is high for the cycle after the edge that samples `eng_resp_valid`.
- Without a response, `done` with `timeout` follows `eng_start` by TIMEOUT+1 cycles.
- `sd_csn` falls together with `eng_start`. It rises at the first GAP cycle unless locked.
- GAP lasts exactly GAP_CLKS cycles.
- From GAP end to the next `eng_start`:
  - Relock: 1 cycle.
  - Via IDLE: 2 cycles.

## Test plan
- Single request: `req`=01, `cmd0`=48'h40_0000_0000_95, engine answers 8'h01 five cycles after start.
  - `gnt`=01; `eng_cmd`=`cmd0`; `eng_start` 2 cycles after `req`.
  - `done` with `resp`=8'h01, `timeout`=0.
  - `sd_csn` high for 8 cycles, then `gnt`=00.
- Tie: `req`=11 held across two commands.
  - Grants go 01 then 10, each with its own frame on `eng_cmd`.
  - `sd_csn` is high for GAP_CLKS cycles between the two commands.
- No response: TIMEOUT=16, engine silent.
  - `done` 17 cycles after `eng_start`, with `resp`=8'hFF and `timeout`=1.
- Lock: requester 1 holds `lock`=1 and `req`=1 while sending CMD55 then ACMD41 (driver changes `cmd1` after the first `done`).
  - `sd_csn` stays 0 throughout.
  - `gnt` stays 10 even while `req`[0]=1.
  - Second `eng_start` 1 cycle after GAP end.
- Simultaneous events: `eng_resp_valid` coincides with timeout expiry, giving `resp`=`eng_resp` and `timeout`=0. Separately, hold `eng_busy`=1 for 10 cycles in ISSUE: `eng_start` is delayed until `eng_busy` falls.
- Reset in WAIT: `rst` pulse gives `sd_csn`=1, `gnt`=00, `done`=0, `resp`=8'hFF at once. A subsequent `req`=10 is served normally.
